// File: rtl/bw_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : bw_mac_accumulator
// Purpose  : Accumulates a valid/ready stream of (M+N)-bit Baugh-Wooley
//            products into an ACC_W-bit sum. On the frame-last beat the sum,
//            the saturating beat count and a sticky overflow flag are
//            presented as a result that is held until the consumer takes it.
// Ports    : clk, rst             clock, synchronous active-high reset
//            clear                synchronous frame abort (below rst)
//            signed_mode          1 = two's-complement products
//            in_valid/in_ready    product stream handshake
//            in_prod, in_last     product beat and frame-last marker
//            out_valid/out_ready  result handshake
//            out_sum, out_count,  frame sum (wraps), beat count (saturates),
//            out_ovf              overflow seen during the frame
// Revision : 1.0  initial release
// ============================================================================
module bw_mac_accumulator #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               signed_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [M+N-1:0]     in_prod,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_ovf
);

    localparam int c_PW = M + N;

    generate
        if (ACC_W < c_PW) begin : g_bad_acc_w
            $error("bw_mac_accumulator: ACC_W must be >= M+N");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_first;
    logic               r_mode_q;

    logic               w_accept;
    logic               w_mode;
    logic [ACC_W-1:0]   w_ext_s;
    logic [ACC_W-1:0]   w_ext_u;
    logic [ACC_W-1:0]   w_ext;
    logic [ACC_W:0]     w_sum;
    logic               w_ov;
    logic [CNT_W-1:0]   w_cnt_inc;

    // in_ready comes straight from the state register, so neither in_valid
    // nor out_ready can reach an output combinationally.
    assign in_ready = (r_state == ST_ACC);

    // clear drops a beat offered in the same cycle.
    assign w_accept = in_valid && in_ready && !clear;

    // First beat of a frame uses the live mode; later beats use the copy
    // captured on that first beat.
    assign w_mode  = r_first ? signed_mode : r_mode_q;
    assign w_ext_s = ACC_W'($signed(in_prod));
    assign w_ext_u = ACC_W'(in_prod);
    assign w_ext   = w_mode ? w_ext_s : w_ext_u;

    assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};

    // Signed: equal operand signs with a differing result sign.
    // Unsigned: carry out of the top accumulator bit.
    assign w_ov = w_mode
                ? ((r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]))
                : w_sum[ACC_W];

    assign w_cnt_inc = (&r_cnt) ? r_cnt : (r_cnt + CNT_W'(1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACC: begin
                if (w_accept && in_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_valid && out_ready) begin
                    w_state_next = ST_ACC;
                end
            end
            default: w_state_next = ST_ACC;
        endcase
        if (clear) begin
            w_state_next = ST_ACC;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator datapath and held result
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_first   <= 1'b1;
            r_mode_q  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_first   <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (r_state == ST_DONE && out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (r_first) begin
                    r_mode_q <= signed_mode;
                end
                if (in_last) begin
                    out_sum   <= w_sum[ACC_W-1:0];
                    out_count <= w_cnt_inc;
                    out_ovf   <= r_ovf | w_ov;
                    out_valid <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf     <= 1'b0;
                    r_first   <= 1'b1;
                end else begin
                    r_acc     <= w_sum[ACC_W-1:0];
                    r_cnt     <= w_cnt_inc;
                    r_ovf     <= r_ovf | w_ov;
                    r_first   <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
